// File: rtl/multi_pulse_extender.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | multi_pulse_extender: per-channel rising-edge pulse stretcher with       |
// | set/ack length/mode config. Optional: PULSE_EXT_OVERRUN_EN (out_overrun) |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module multi_pulse_extender #(
    parameter int CHANNELS    = 4,
    parameter int CNT_WIDTH   = 8,
    parameter int DEFAULT_LEN = 1,
    parameter int CH_WIDTH    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 in_clock,
    input  logic                 in_reset_n,
    input  logic                 in_set,
    input  logic [CH_WIDTH-1:0]  in_channel,
    input  logic [CNT_WIDTH-1:0] in_value,
    input  logic                 in_retrig,
    output logic                 out_ack,
    input  logic [CHANNELS-1:0]  in_signal,
    output logic [CHANNELS-1:0]  out_signal,
`ifdef PULSE_EXT_OVERRUN_EN
    output logic [CHANNELS-1:0]  out_overrun,
`endif
    output logic                 out_busy
);

    localparam logic [CNT_WIDTH-1:0] c_default_len = CNT_WIDTH'(DEFAULT_LEN);
    localparam logic [CNT_WIDTH-1:0] c_one         = CNT_WIDTH'(1);

    logic r_ack;

    always_ff @(posedge in_clock) begin
        if (!in_reset_n) begin
            r_ack <= 1'b0;
        end else begin
            r_ack <= in_set;
        end
    end

    assign out_ack  = r_ack;
    assign out_busy = |out_signal;

    genvar c;
    generate
        for (c = 0; c < CHANNELS; c++) begin : g_chan
            logic [CNT_WIDTH-1:0] r_len;
            logic [CNT_WIDTH-1:0] r_cnt;
            logic                 r_retrig;
            logic                 r_prev;
            logic                 r_out;
            logic [CNT_WIDTH-1:0] w_cnt_next;
            logic                 w_trig;
            logic                 w_wr;
            logic                 w_load;

            // Trigger sees the pre-write length/mode, so same-edge writes only affect later triggers.
            always_comb begin
                w_trig     = in_signal[c] & ~r_prev;
                w_wr       = in_set && (in_channel == CH_WIDTH'(c));
                w_load     = w_trig && (r_len != '0) && ((r_cnt == '0) || r_retrig);
                w_cnt_next = '0;
                if (w_load) begin
                    w_cnt_next = r_len;
                end else if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - c_one;
                end
            end

            always_ff @(posedge in_clock) begin
                if (!in_reset_n) begin
                    r_len    <= c_default_len;
                    r_retrig <= 1'b0;
                    r_cnt    <= '0;
                    r_prev   <= 1'b1;
                    r_out    <= 1'b0;
                end else begin
                    r_prev <= in_signal[c];
                    r_cnt  <= w_cnt_next;
                    r_out  <= (w_cnt_next != '0);
                    if (w_wr) begin
                        r_len    <= in_value;
                        r_retrig <= in_retrig;
                    end
                end
            end

            assign out_signal[c] = r_out;

`ifdef PULSE_EXT_OVERRUN_EN
            logic r_ovr;

            // Clear beats set when a write and an overlapping trigger share an edge.
            always_ff @(posedge in_clock) begin
                if (!in_reset_n) begin
                    r_ovr <= 1'b0;
                end else if (w_wr) begin
                    r_ovr <= 1'b0;
                end else if (w_trig && (r_cnt != '0)) begin
                    r_ovr <= 1'b1;
                end
            end

            assign out_overrun[c] = r_ovr;
`endif
        end
    endgenerate

endmodule
`default_nettype wire
